circular_word_shifter: RTL and testbench

Registered circular (rotate) shifter over a bus of 33 packed 32-bit words, sitting between the B-row data buffer and the C-feed of the matrix-multiply array. It rotates the word vector up or down by a programmable word step, with one cycle of latency. A bypass mode connects input straight to output.

---
 rtl/circular_word_shifter_pkg.sv | 21 ++
 rtl/circular_word_shifter_if.sv | 24 ++
 rtl/circular_word_shifter_word_rotator.sv | 35 +++
 rtl/circular_word_shifter.sv | 37 +++
 tb/tb_circular_word_shifter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/circular_word_shifter_pkg.sv
// Shared widths and types for the circular word shifter between the B-row
// buffer and the C-feed of the matrix-multiply array.
package circular_word_shifter_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 33;
  localparam int BUS_W     = WORD_W * NUM_WORDS;
  localparam int STEP_W    = 7;
  localparam int IDX_W     = 6;

  typedef logic [WORD_W-1:0]                 word_t;
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0]  bus_t;
  typedef logic [STEP_W-1:0]                 step_t;
  typedef logic [IDX_W-1:0]                  idx_t;

  // Any 7-bit step is legal; only its residue modulo the word count matters.
  function automatic idx_t reduce_step(input step_t step);
    return IDX_W'(step % STEP_W'(NUM_WORDS));
  endfunction

endpackage

// File: rtl/circular_word_shifter_if.sv
// Data/control bundle of the circular word shifter; the master drives the
// words and shift controls, the slave (the shifter) returns the result.
interface circular_word_shifter_if;
  import circular_word_shifter_pkg::*;

  bus_t  dataBr_Cf_in;
  logic  shift_direction;
  step_t step_size;
  logic  shift_enable;
  logic  direct_connection;
  bus_t  dataBr_Cf_out;
  logic  shift_ready;

  modport master (
    output dataBr_Cf_in, shift_direction, step_size, shift_enable, direct_connection,
    input  dataBr_Cf_out, shift_ready
  );

  modport slave (
    input  dataBr_Cf_in, shift_direction, step_size, shift_enable, direct_connection,
    output dataBr_Cf_out, shift_ready
  );

endinterface

// File: rtl/circular_word_shifter_word_rotator.sv
// Combinational word rotator: one 33:1 word mux per output position, with the
// source index derived from the step reduced modulo the word count.
module word_rotator
  import circular_word_shifter_pkg::*;
(
  input  bus_t  data_in,
  input  logic  shift_direction,
  input  step_t step_size,
  output bus_t  data_out
);

  idx_t k;
  logic [IDX_W:0] sum [NUM_WORDS];
  idx_t src [NUM_WORDS];

  assign k = reduce_step(step_size);

  // Direction 0 pulls from i+k, direction 1 from i-k; one wrap subtraction suffices.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      sum[i] = '0;
      src[i] = '0;
      if (shift_direction)
        sum[i] = (IDX_W+1)'(i) + (IDX_W+1)'(NUM_WORDS) - {1'b0, k};
      else
        sum[i] = (IDX_W+1)'(i) + {1'b0, k};
      if (sum[i] >= (IDX_W+1)'(NUM_WORDS))
        sum[i] = sum[i] - (IDX_W+1)'(NUM_WORDS);
      src[i] = sum[i][IDX_W-1:0];
      data_out[i] = data_in[src[i]];
    end
  end

endmodule

// File: rtl/circular_word_shifter.sv
// Registered circular word shifter with one cycle of latency and a
// combinational bypass that takes priority over the registered result.
module circular_word_shifter
  import circular_word_shifter_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  circular_word_shifter_if.slave bus
);

  bus_t rot_data;
  bus_t out_q;
  logic ready_q;

  word_rotator u_word_rotator (
    .data_in         (bus.dataBr_Cf_in),
    .shift_direction (bus.shift_direction),
    .step_size       (bus.step_size),
    .data_out        (rot_data)
  );

  // The register keeps loading under shift_enable even while bypass is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (bus.shift_enable)
        out_q <= rot_data;
      ready_q <= bus.shift_enable;
    end
  end

  assign bus.dataBr_Cf_out = bus.direct_connection ? bus.dataBr_Cf_in : out_q;
  assign bus.shift_ready   = bus.direct_connection | ready_q;

endmodule

// File: tb/tb_circular_word_shifter.sv
// Self-checking bench for circular_word_shifter: directed test-plan steps plus
// randomized traffic against an index-arithmetic reference model.
module tb_circular_word_shifter;
  import circular_word_shifter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bus_t model_reg;
  logic model_ready;
  bus_t pattern_common;
  bus_t pattern_index;
  bus_t rand_data;

  circular_word_shifter_if sif ();

  circular_word_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bus_t refRotate(input bus_t d, input logic dir, input step_t step);
    bus_t r;
    int   k;
    int   src;
    k = int'(step) % NUM_WORDS;
    for (int i = 0; i < NUM_WORDS; i++) begin
      src  = dir ? (i - k + NUM_WORDS) % NUM_WORDS : (i + k) % NUM_WORDS;
      r[i] = d[src];
    end
    return r;
  endfunction

  task automatic applyStimulus(input bus_t data, input logic dir, input step_t step,
                               input logic en, input logic byp);
    sif.dataBr_Cf_in      = data;
    sif.shift_direction   = dir;
    sif.step_size         = step;
    sif.shift_enable      = en;
    sif.direct_connection = byp;
  endtask

  // Advance one edge; the model takes the inputs present at that edge.
  task automatic tickClock();
    if (sif.shift_enable)
      model_reg = refRotate(sif.dataBr_Cf_in, sif.shift_direction, sif.step_size);
    model_ready = sif.shift_enable;
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input int idx, input word_t exp);
    checks++;
    assert (sif.dataBr_Cf_out[idx] === exp) else begin
      failures++;
      $error("[TB] FAIL %s word%0d observed=%h expected=%h", tag, idx, sif.dataBr_Cf_out[idx], exp);
    end
  endtask

  task automatic checkBus(input string tag, input bus_t exp);
    int first;
    checks++;
    assert (sif.dataBr_Cf_out === exp) else begin
      failures++;
      first = 0;
      for (int i = NUM_WORDS - 1; i >= 0; i--)
        if (sif.dataBr_Cf_out[i] !== exp[i]) first = i;
      $error("[TB] FAIL %s word%0d observed=%h expected=%h", tag, first,
             sif.dataBr_Cf_out[first], exp[first]);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBus({tag, "_out"}, sif.direct_connection ? sif.dataBr_Cf_in : model_reg);
    checkBit({tag, "_ready"}, sif.shift_ready, sif.direct_connection | model_ready);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_reg   = '0;
    model_ready = 1'b0;

    pattern_common     = '0;
    pattern_common[0]  = 32'h11111111;
    pattern_common[32] = 32'h11111111;
    pattern_common[1]  = 32'h22222222;
    pattern_common[31] = 32'h22222222;
    pattern_common[2]  = 32'h33333333;
    pattern_common[30] = 32'h33333333;
    for (int i = 0; i < NUM_WORDS; i++) pattern_index[i] = word_t'(i);

    // Reset and idle
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, '0, 1'b0, 1'b0);
    #3;
    checkBus("reset_out", '0);
    checkBit("reset_ready", sif.shift_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tickClock();
    checkBus("idle_out", '0);
    checkBit("idle_ready", sif.shift_ready, 1'b0);

    // Direction 1, step 2, single-cycle enable pulse
    applyStimulus(pattern_common, 1'b1, 7'd2, 1'b1, 1'b0);
    tickClock();
    checkWord("down2", 0, 32'h22222222);
    checkWord("down2", 1, 32'h11111111);
    checkWord("down2", 2, 32'h11111111);
    checkWord("down2", 3, 32'h22222222);
    checkWord("down2", 4, 32'h33333333);
    checkWord("down2", 31, 32'h00000000);
    checkWord("down2", 32, 32'h33333333);
    checkOutput("down2");
    applyStimulus(pattern_common, 1'b0, 7'd3, 1'b0, 1'b0);
    tickClock();
    checkBit("down2_ready_drop", sif.shift_ready, 1'b0);
    checkWord("down2_hold", 0, 32'h22222222);
    checkOutput("down2_hold");

    // Direction 0, step 3, enable held
    applyStimulus(pattern_common, 1'b0, 7'd3, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tickClock();
      checkWord("up3", 0, 32'h00000000);
      checkWord("up3", 27, 32'h33333333);
      checkWord("up3", 28, 32'h22222222);
      checkWord("up3", 29, 32'h11111111);
      checkWord("up3", 30, 32'h11111111);
      checkWord("up3", 31, 32'h22222222);
      checkWord("up3", 32, 32'h33333333);
      checkBit("up3_ready", sif.shift_ready, 1'b1);
    end

    // Step boundaries on the word-index pattern
    applyStimulus(pattern_index, 1'b0, 7'd0, 1'b1, 1'b0);
    tickClock();
    checkBus("step0_identity", pattern_index);
    applyStimulus(pattern_index, 1'b1, 7'd33, 1'b1, 1'b0);
    tickClock();
    checkBus("step33_identity", pattern_index);
    applyStimulus(pattern_index, 1'b0, 7'd34, 1'b1, 1'b0);
    tickClock();
    checkWord("step34_up", 0, 32'd1);
    checkWord("step34_up", 32, 32'd0);
    applyStimulus(pattern_index, 1'b1, 7'd32, 1'b1, 1'b0);
    tickClock();
    checkWord("step32_down", 0, 32'd1);
    checkOutput("step32_down");

    // Bypass is combinational; register still loads underneath it
    applyStimulus(pattern_index, 1'b0, 7'd3, 1'b1, 1'b1);
    #1;
    checkBus("bypass_comb", pattern_index);
    checkBit("bypass_ready", sif.shift_ready, 1'b1);
    tickClock();
    applyStimulus(pattern_index, 1'b0, 7'd3, 1'b0, 1'b0);
    #1;
    checkWord("bypass_release", 0, 32'd3);
    checkWord("bypass_release", 32, 32'd2);
    checkOutput("bypass_release");
    tickClock();

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NUM_WORDS; i++) rand_data[i] = $urandom;
      applyStimulus(rand_data, 1'($urandom), 7'($urandom), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 4) == 0));
      tickClock();
      checkOutput("random");
    end

    // Asynchronous reset mid-run, no clock edge required
    applyStimulus(pattern_common, 1'b1, 7'd5, 1'b1, 1'b0);
    tickClock();
    checkOutput("pre_reset");
    #2;
    rst_n = 1'b0;
    model_reg   = '0;
    model_ready = 1'b0;
    #1;
    checkBus("midreset_out", '0);
    checkBit("midreset_ready", sif.shift_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(pattern_common, 1'b1, 7'd5, 1'b0, 1'b0);
    tickClock();
    checkOutput("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
